// File: rtl/sd_axi_rd_fetch.sv
// sd_axi_rd_fetch: AXI4 read master fetching 512-byte sectors from DDR as 16-beat INCR bursts
// and streaming them LSB-halfword-first to the SD writer with valid/ready flow control.
// Ports: clk/rst_n (async active-low), start/rd_base_addr/sec_num/busy/done control,
// sd_wr_* halfword stream, model_ar*/model_r* AXI read channels, err sticky error.
// Optional: define SD_AXI_RD_ERR_CHK_EN to flag rresp/rid errors, drain the burst and finish early.
module sd_axi_rd_fetch #(
  parameter int                  DATA_WIDTH = 256,
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  ID_WIDTH   = 8,
  parameter logic [ID_WIDTH-1:0] ID         = 8'h41,
  parameter int                  BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] rd_base_addr,
  input  logic [31:0]           sec_num,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           sd_wr_data,
  output logic                  sd_wr_valid,
  input  logic                  sd_wr_ready,
  output logic                  sd_wr_last,
  output logic [ID_WIDTH-1:0]   model_arid,
  output logic [ADDR_WIDTH-1:0] model_araddr,
  output logic [7:0]            model_arlen,
  output logic [2:0]            model_arsize,
  output logic [1:0]            model_arburst,
  output logic                  model_arlock,
  output logic [3:0]            model_arcache,
  output logic [2:0]            model_arprot,
  output logic                  model_arvalid,
  input  logic                  model_arready,
  input  logic [ID_WIDTH-1:0]   model_rid,
  input  logic [DATA_WIDTH-1:0] model_rdata,
  input  logic [1:0]            model_rresp,
  input  logic                  model_rlast,
  input  logic                  model_rvalid,
  output logic                  model_rready,
  output logic                  err
);
  localparam int HW_BITS = $clog2(DATA_WIDTH / 16);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, FLUSH, FIN} state_t;
  state_t                state_q;
  logic                  busy_q, done_q, arvalid_q, beat_full_q, beat_last_q, err_q, drop_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [31:0]           num_q, sec_idx_q;
  logic [DATA_WIDTH-1:0] beat_q;
  logic [HW_BITS-1:0]    hw_q;
  logic                  r_fire, w_fire, bad, more;
`ifdef SD_AXI_RD_ERR_CHK_EN
  assign bad = (model_rresp != 2'b00) || (model_rid != ID);
`else
  logic unused_rsp;
  assign unused_rsp = ^{model_rid, model_rresp};
  assign bad = 1'b0;
`endif
  assign model_arid    = ID;
  assign model_araddr  = araddr_q;
  assign model_arlen   = 8'(BURST_LEN - 1);
  assign model_arsize  = 3'd5;
  assign model_arburst = 2'b01;
  assign model_arlock  = 1'b0;
  assign model_arcache = 4'b0011;
  assign model_arprot  = 3'd0;
  assign model_arvalid = arvalid_q;
  // once an error is seen the rest of the burst is swallowed regardless of the beat buffer
  assign model_rready  = (state_q == DATA) && (drop_q || !beat_full_q);
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign sd_wr_valid   = beat_full_q;
  assign sd_wr_data    = beat_q[{hw_q, 4'b0000} +: 16];
  assign sd_wr_last    = beat_full_q && (&hw_q) && beat_last_q;
  assign r_fire        = model_rvalid && model_rready;
  assign w_fire        = beat_full_q && sd_wr_ready;
  assign more          = (sec_idx_q + 32'd1) < num_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      num_q       <= '0;
      sec_idx_q   <= '0;
      beat_q      <= '0;
      beat_full_q <= 1'b0;
      beat_last_q <= 1'b0;
      hw_q        <= '0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (w_fire) begin
        hw_q <= hw_q + 1'b1;
        if (&hw_q) beat_full_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (start) begin
          busy_q    <= 1'b1;
          err_q     <= 1'b0;
          drop_q    <= 1'b0;
          num_q     <= sec_num;
          sec_idx_q <= '0;
          araddr_q  <= rd_base_addr & ~ADDR_WIDTH'(511);
          arvalid_q <= sec_num != 32'd0;
          state_q   <= (sec_num == 32'd0) ? FIN : ADDR;
        end
        ADDR: if (model_arready) begin
          arvalid_q <= 1'b0;
          state_q   <= DATA;
        end
        DATA: if (r_fire) begin
          // the beat buffer is only ever loaded while empty, so the serializer never collides with it
          if (!drop_q && !bad) begin
            beat_q      <= model_rdata;
            beat_full_q <= 1'b1;
            beat_last_q <= model_rlast;
            hw_q        <= '0;
          end
          if (bad) begin
            err_q  <= 1'b1;
            drop_q <= 1'b1;
          end
          if (model_rlast) begin
            sec_idx_q <= sec_idx_q + 32'd1;
            if (!drop_q && !bad && more) begin
              arvalid_q <= 1'b1;
              araddr_q  <= araddr_q + ADDR_WIDTH'(512);
              state_q   <= ADDR;
            end else begin
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: if (!beat_full_q) state_q <= FIN;
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_axi_rd_fetch.sv
// tb_sd_axi_rd_fetch: directed bench with a reactive AXI read slave and halfword scoreboard
module tb_sd_axi_rd_fetch;
  logic         clk = 1'b0;
  logic         rst_n, start, busy, done, err;
  logic [31:0]  rd_base_addr, sec_num;
  logic [15:0]  sd_wr_data;
  logic         sd_wr_valid, sd_wr_ready, sd_wr_last;
  logic [7:0]   arid, arlen, rid;
  logic [31:0]  araddr;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst, rresp;
  logic         arlock, arvalid, arready;
  logic [3:0]   arcache;
  logic [255:0] rdata;
  logic         rlast, rvalid, rready;
  int           n_chk = 0, n_fail = 0;
  int           w_idx = 0, last_cnt = 0, ar_cnt = 0, burst_n = 0, beat = 0;
  logic [31:0]  bq[$];
  logic [31:0]  ar_log[8];
  logic [31:0]  mem_base = 32'h0;
  bit           stall = 0, err_on = 0, r_pend = 0, held_v = 0;
  logic [15:0]  held_d;
  always #5 clk = ~clk;
  sd_axi_rd_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_base_addr(rd_base_addr), .sec_num(sec_num),
    .busy(busy), .done(done), .sd_wr_data(sd_wr_data), .sd_wr_valid(sd_wr_valid),
    .sd_wr_ready(sd_wr_ready), .sd_wr_last(sd_wr_last), .model_arid(arid), .model_araddr(araddr),
    .model_arlen(arlen), .model_arsize(arsize), .model_arburst(arburst), .model_arlock(arlock),
    .model_arcache(arcache), .model_arprot(arprot), .model_arvalid(arvalid), .model_arready(arready),
    .model_rid(rid), .model_rdata(rdata), .model_rresp(rresp), .model_rlast(rlast),
    .model_rvalid(rvalid), .model_rready(rready), .err(err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // memory holds the halfword index relative to mem_base, so the stream reads 0,1,2,...
  function automatic logic [255:0] beat_data(input logic [31:0] a);
    logic [255:0] d;
    for (int h = 0; h < 16; h++) d[16*h +: 16] = 16'((a + 32'(2 * h) - mem_base) >> 1);
    return d;
  endfunction
  always begin
    @(negedge clk);
    if (!rst_n) begin
      bq.delete();
      beat = 0; rvalid = 0; rlast = 0; rresp = 0; rid = 8'h41; rdata = '0;
      arready = 0; sd_wr_ready = 0; r_pend = 0; held_v = 0;
    end else begin
      arready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      sd_wr_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!r_pend) rvalid = (bq.size() > 0) && (!stall || $urandom_range(0, 3) != 0);
      if (bq.size() > 0) begin
        rdata = beat_data(bq[0] + 32'(32 * beat));
        rlast = (beat == 15);
        rresp = (err_on && burst_n == 0 && beat == 4) ? 2'b10 : 2'b00;
      end
      #2;
      if (arvalid && arready) begin
        bq.push_back(araddr);
        if (ar_cnt < 8) ar_log[ar_cnt] = araddr;
        ar_cnt++;
      end
      r_pend = rvalid && !rready;
      if (rvalid && rready) begin
        beat++;
        if (beat == 16) begin
          beat = 0;
          void'(bq.pop_front());
          burst_n++;
        end
      end
      if (held_v) begin
        chk("hold_data", sd_wr_data, held_d);
        chk("hold_valid", sd_wr_valid, 1);
      end
      held_v = sd_wr_valid && !sd_wr_ready;
      held_d = sd_wr_data;
      if (sd_wr_valid && sd_wr_ready) begin
        chk("word", sd_wr_data, 16'(w_idx));
        chk("word_last", sd_wr_last, w_idx % 256 == 255);
        last_cnt += int'(sd_wr_last);
        w_idx++;
      end
    end
  end
  task automatic go(input logic [31:0] b, input logic [31:0] n);
    @(negedge clk);
    rd_base_addr = b; sec_num = n; start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic clear(input logic [31:0] b);
    w_idx = 0; last_cnt = 0; ar_cnt = 0; burst_n = 0; mem_base = b;
  endtask
  task automatic wait_done(input int max, input string tag);
    int c = 0;
    while (done !== 1'b1 && c < max) begin
      @(posedge clk); #1; c++;
    end
    chk(tag, done, 1);
    chk({tag, "_busy"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 0);
  endtask
  initial begin
    rst_n = 0; start = 0; rd_base_addr = 0; sec_num = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_valid", sd_wr_valid, 0);
    chk("rst_last", sd_wr_last, 0); chk("rst_arvalid", arvalid, 0); chk("rst_rready", rready, 0);
    chk("rst_err", err, 0); chk("rst_araddr", araddr, 0);
    @(negedge clk); rst_n = 1;
    // single sector, no stalls
    clear(32'h1000);
    go(32'h1000, 1);
    chk("t1_busy", busy, 1); chk("t1_arvalid", arvalid, 1); chk("t1_araddr", araddr, 32'h1000);
    chk("t1_arlen", arlen, 8'h0f); chk("t1_arsize", arsize, 3'd5); chk("t1_arburst", arburst, 2'b01);
    chk("t1_arid", arid, 8'h41); chk("t1_arcache", arcache, 4'b0011);
    chk("t1_arlock", arlock, 0); chk("t1_arprot", arprot, 0);
    wait_done(3000, "t1_done");
    chk("t1_words", w_idx, 256); chk("t1_lasts", last_cnt, 1); chk("t1_ars", ar_cnt, 1);
    // three sectors with random stalls on every channel
    clear(32'h2000); stall = 1;
    go(32'h2000, 3);
    wait_done(20000, "t2_done");
    chk("t2_words", w_idx, 768); chk("t2_lasts", last_cnt, 3); chk("t2_ars", ar_cnt, 3);
    chk("t2_ar0", ar_log[0], 32'h2000); chk("t2_ar1", ar_log[1], 32'h2200); chk("t2_ar2", ar_log[2], 32'h2400);
    stall = 0;
    // zero sectors: done two cycles after start, no AR
    clear(32'h0);
    @(negedge clk); rd_base_addr = 32'h5000; sec_num = 0; start = 1;
    @(posedge clk); #1;
    chk("t3_done0", done, 0); chk("t3_busy", busy, 1);
    @(negedge clk); start = 0;
    @(posedge clk); #1;
    chk("t3_done", done, 1); chk("t3_busy_lo", busy, 0); chk("t3_arvalid", arvalid, 0);
    @(posedge clk); #1;
    chk("t3_pulse", done, 0); chk("t3_ars", ar_cnt, 0);
    // start while busy is ignored; unaligned base is truncated to the sector
    clear(32'h4000);
    go(32'h41a4, 2);
    repeat (20) @(negedge clk);
    go(32'h8000, 5);
    chk("t4_busy", busy, 1);
    wait_done(4000, "t4_done");
    repeat (3) @(posedge clk); #1;
    chk("t4_idle", busy, 0); chk("t4_ars", ar_cnt, 2); chk("t4_words", w_idx, 512);
    chk("t4_ar0", ar_log[0], 32'h4000); chk("t4_ar1", ar_log[1], 32'h4200);
    // reset while sector 2 streams, then a fresh transfer
    clear(32'h6000);
    go(32'h6000, 3);
    for (int c = 0; c < 2000 && ar_cnt < 2; c++) @(negedge clk);
    chk("t5_ar2_seen", ar_cnt, 2);
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    chk("t5_busy", busy, 0); chk("t5_valid", sd_wr_valid, 0); chk("t5_arvalid", arvalid, 0);
    chk("t5_rready", rready, 0); chk("t5_araddr", araddr, 0); chk("t5_last", sd_wr_last, 0);
    repeat (2) @(negedge clk);
    clear(32'h1000);
    rst_n = 1;
    go(32'h1000, 1);
    wait_done(3000, "t5_done");
    chk("t5_words", w_idx, 256); chk("t5_ars", ar_cnt, 1); chk("t5_ar0", ar_log[0], 32'h1000);
    // error response on beat 4 of the first sector
    clear(32'h3000); err_on = 1;
    go(32'h3000, 2);
    wait_done(4000, "t6_done");
    err_on = 0;
`ifdef SD_AXI_RD_ERR_CHK_EN
    chk("t6_err", err, 1); chk("t6_words", w_idx, 64); chk("t6_ars", ar_cnt, 1);
    chk("t6_drained", bq.size(), 0); chk("t6_lasts", last_cnt, 0);
    clear(32'h1000);
    go(32'h1000, 1);
    chk("t6_err_clr", err, 0);
    wait_done(3000, "t6_done2");
    chk("t6_words2", w_idx, 256);
`else
    chk("t6_err", err, 0); chk("t6_words", w_idx, 512); chk("t6_ars", ar_cnt, 2);
    chk("t6_lasts", last_cnt, 2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
